// File: rtl/mcdf_pkg.sv
// Shared types and constants for the uplink arbiter: FSM states, channel ids,
// data width and the packet-length decode.
package mcdf_pkg;

  localparam int DATA_WIDE = 32;
  localparam int NUM_CH    = 3;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam logic [1:0] CHID_IDLE = 2'b00;
  localparam logic [1:0] CHID_CH0  = 2'b01;
  localparam logic [1:0] CHID_CH1  = 2'b10;
  localparam logic [1:0] CHID_CH2  = 2'b11;

  // Codes above 3 saturate at the maximum packet size.
  function automatic logic [5:0] len_decode(input logic [2:0] code);
    case (code)
      3'd0:    len_decode = 6'd4;
      3'd1:    len_decode = 6'd8;
      3'd2:    len_decode = 6'd16;
      default: len_decode = 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/arbiter_if.sv
// Channel-side and uplink-side handshake bundle of the arbiter.
// slave = arbiter side, master = the environment driving channels and the uplink sink.
interface arbiter_if;

  logic                           ch0_valid, ch1_valid, ch2_valid;
  logic [mcdf_pkg::DATA_WIDE-1:0] ch0_data, ch1_data, ch2_data;
  logic                           ch0_ready, ch1_ready, ch2_ready;
  logic [1:0]                     ch0_prio, ch1_prio, ch2_prio;
  logic [2:0]                     ch0_len, ch1_len, ch2_len;
  logic [2:0]                     ch_en;
  logic                           arb_uplink_ready;
  logic                           arb_uplink_valid;
  logic [1:0]                     arb_uplink_chid;
  logic [mcdf_pkg::DATA_WIDE-1:0] arb_uplink_data;

  modport slave (
    input  ch0_valid, ch1_valid, ch2_valid,
    input  ch0_data, ch1_data, ch2_data,
    input  ch0_prio, ch1_prio, ch2_prio,
    input  ch0_len, ch1_len, ch2_len,
    input  ch_en, arb_uplink_ready,
    output ch0_ready, ch1_ready, ch2_ready,
    output arb_uplink_valid, arb_uplink_chid, arb_uplink_data
  );

  modport master (
    output ch0_valid, ch1_valid, ch2_valid,
    output ch0_data, ch1_data, ch2_data,
    output ch0_prio, ch1_prio, ch2_prio,
    output ch0_len, ch1_len, ch2_len,
    output ch_en, arb_uplink_ready,
    input  ch0_ready, ch1_ready, ch2_ready,
    input  arb_uplink_valid, arb_uplink_chid, arb_uplink_data
  );

endinterface

// File: rtl/arb_pick.sv
// Combinational winner select: lowest prio value wins, ties go round-robin
// starting at the channel after last. One-hot grant, all-zero with no candidates.
module arb_pick
  import mcdf_pkg::*;
(
  input  logic [NUM_CH-1:0]      cand,
  input  logic [NUM_CH-1:0][1:0] prio,
  input  logic [1:0]             last,
  output logic [NUM_CH-1:0]      grant
);

  logic [1:0] best_prio;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    best_prio = 2'd3;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cand[i] && (prio[i] < best_prio)) best_prio = prio[i];
    end

    // Walk the ring once, beginning just past the last winner.
    grant = '0;
    found = 1'b0;
    idx   = last;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (!found && cand[idx] && (prio[idx] == best_prio)) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbiter.sv
// Three-channel packet arbiter: grant registers in IDLE, then XFER streams len words with
// combinational valid/data/ready pass-through; uplink backpressure or source bubbles stall the beat count.
module arbiter
  import mcdf_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  arbiter_if.slave bus
);

  state_t                          state, state_n;
  logic [5:0]                      cnt, cnt_n;
  logic [5:0]                      len_q, len_n;
  logic [1:0]                      sel, sel_n;
  logic [1:0]                      last, last_n;
  logic [NUM_CH-1:0]               valid_v, cand, grant, ready_v;
  logic [NUM_CH-1:0][1:0]          prio_v;
  logic [NUM_CH-1:0][2:0]          len_v;
  logic [NUM_CH-1:0][DATA_WIDE-1:0] data_v;

  assign valid_v = {bus.ch2_valid, bus.ch1_valid, bus.ch0_valid};
  assign prio_v  = {bus.ch2_prio, bus.ch1_prio, bus.ch0_prio};
  assign len_v   = {bus.ch2_len, bus.ch1_len, bus.ch0_len};
  assign data_v  = {bus.ch2_data, bus.ch1_data, bus.ch0_data};
  assign cand    = valid_v & bus.ch_en;

  arb_pick u_pick (
    .cand  (cand),
    .prio  (prio_v),
    .last  (last),
    .grant (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      len_q <= 6'd4;
      sel   <= 2'd0;
      last  <= 2'd2;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      len_q <= len_n;
      sel   <= sel_n;
      last  <= last_n;
    end
  end

  always_comb begin
    state_n              = state;
    cnt_n                = cnt;
    len_n                = len_q;
    sel_n                = sel;
    last_n               = last;
    ready_v              = '0;
    bus.arb_uplink_valid = 1'b0;
    bus.arb_uplink_data  = '0;
    bus.arb_uplink_chid  = CHID_IDLE;

    case (state)
      IDLE: begin
        if (|grant) begin
          state_n = XFER;
          sel_n   = grant[1] ? 2'd1 : (grant[2] ? 2'd2 : 2'd0);
          len_n   = len_decode(len_v[sel_n]);
          cnt_n   = '0;
        end
      end
      XFER: begin
        bus.arb_uplink_valid = valid_v[sel];
        bus.arb_uplink_data  = data_v[sel];
        bus.arb_uplink_chid  = (sel == 2'd0) ? CHID_CH0 : ((sel == 2'd1) ? CHID_CH1 : CHID_CH2);
        ready_v[sel]         = bus.arb_uplink_ready;
        if (valid_v[sel] && bus.arb_uplink_ready) begin
          if (cnt == len_q - 6'd1) begin
            state_n = IDLE;
            cnt_n   = '0;
            last_n  = sel;
          end else begin
            cnt_n = cnt + 6'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.ch0_ready = ready_v[0];
  assign bus.ch1_ready = ready_v[1];
  assign bus.ch2_ready = ready_v[2];

endmodule

// File: tb/tb_arbiter.sv
// Scenario bench for the arbiter: per-cycle comparison against a packet-level reference
// model plus grant-order and data-order checks on the observed uplink stream.
module tb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  arbiter_if bus ();

  arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source side: each channel offers src_left words, word value = {channel, sequence}.
  int         src_left[3];
  int         seq[3];
  logic [1:0] prio[3];
  logic [2:0] len[3];
  logic [2:0] en;
  logic       cur_vld[3];
  logic       cur_rdy;
  int         rdy_mode;
  bit         drop_en;
  int         cyc = 0;

  // Reference model: packet in flight, channel, words still owed, last granted channel.
  bit m_busy;
  int m_ch, m_rem, m_last;

  int          obs_grant[$];
  logic [31:0] obs_data[$];
  logic [1:0]  prev_chid = 2'b00;

  function automatic logic [31:0] word(int ch);
    return {8'(ch), 24'(seq[ch])};
  endfunction

  function automatic logic [37:0] exp_out();
    logic [2:0] r;
    r = '0;
    if (!m_busy) return '0;
    r[m_ch] = cur_rdy;
    return {cur_vld[m_ch], 2'(m_ch + 1), word(m_ch), r};
  endfunction

  function automatic logic [37:0] act_out();
    return {bus.arb_uplink_valid, bus.arb_uplink_chid, bus.arb_uplink_data,
            bus.ch2_ready, bus.ch1_ready, bus.ch0_ready};
  endfunction

  task automatic present();
    for (int i = 0; i < 3; i++)
      cur_vld[i] = (src_left[i] > 0) && !(drop_en && $urandom_range(3) == 0);
    case (rdy_mode)
      1:       cur_rdy = ((cyc % 2) == 0);
      2:       cur_rdy = 1'($urandom_range(1));
      default: cur_rdy = 1'b1;
    endcase
    bus.ch0_valid = cur_vld[0];  bus.ch1_valid = cur_vld[1];  bus.ch2_valid = cur_vld[2];
    bus.ch0_data  = word(0);     bus.ch1_data  = word(1);     bus.ch2_data  = word(2);
    bus.ch0_prio  = prio[0];     bus.ch1_prio  = prio[1];     bus.ch2_prio  = prio[2];
    bus.ch0_len   = len[0];      bus.ch1_len   = len[1];      bus.ch2_len   = len[2];
    bus.ch_en            = en;
    bus.arb_uplink_ready = cur_rdy;
    #1;
    if (bus.arb_uplink_chid != 2'b00 && prev_chid == 2'b00)
      obs_grant.push_back(int'(bus.arb_uplink_chid) - 1);
    prev_chid = bus.arb_uplink_chid;
    if (bus.arb_uplink_valid && bus.arb_uplink_ready) obs_data.push_back(bus.arb_uplink_data);
  endtask

  task automatic advance();
    int best, score, bscore;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      if (!m_busy) begin
        best   = -1;
        bscore = 1000;
        for (int i = 0; i < 3; i++) begin
          if (en[i] && cur_vld[i]) begin
            score = int'(prio[i]) * 3 + (i - m_last + 2) % 3;
            if (score < bscore) begin
              bscore = score;
              best   = i;
            end
          end
        end
        if (best >= 0) begin
          m_busy = 1;
          m_ch   = best;
          m_rem  = 4 << ((len[best] > 3) ? 3 : int'(len[best]));
        end
      end else if (cur_vld[m_ch] && cur_rdy) begin
        src_left[m_ch]--;
        seq[m_ch]++;
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0;
          m_last = m_ch;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic setup();
    for (int i = 0; i < 3; i++) begin
      src_left[i] = 0;
      seq[i]      = 0;
      prio[i]     = 2'd0;
      len[i]      = 3'd0;
    end
    en       = 3'b111;
    rdy_mode = 0;
    drop_en  = 0;
  endtask

  task automatic apply_reset();
    rst    = 1'b1;
    m_busy = 0;
    m_last = 2;
    present();
    advance();
    rst = 1'b0;
    obs_grant.delete();
    obs_data.delete();
  endtask

  task automatic test_reset();
    setup();
    for (int i = 0; i < 3; i++) src_left[i] = 4;
    rst    = 1'b1;
    m_busy = 0;
    m_last = 2;
    for (int c = 0; c < 3; c++) begin
      present();
      checks++;
      if (act_out() !== 38'd0) begin
        errors++;
        $display("FAIL reset_idle c=%0d got=%h exp=0", c, act_out());
      end
      advance();
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      present();
      checks++;
      if (act_out() !== exp_out()) begin
        errors++;
        $display("FAIL reset_release c=%0d got=%h exp=%h", c, act_out(), exp_out());
      end
      advance();
    end
  endtask

  task automatic test_single();
    int rc = 0;
    setup();
    src_left[0] = 4;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      present();
      checks++;
      if (act_out() !== exp_out()) begin
        errors++;
        $display("FAIL single c=%0d got=%h exp=%h", c, act_out(), exp_out());
      end
      rc += int'(bus.ch0_ready);
      advance();
    end
    checks++;
    if (obs_grant.size() != 1 || obs_grant[0] != 0) begin
      errors++;
      $display("FAIL single_grant got_n=%0d exp_n=1 first=0", obs_grant.size());
    end
    checks++;
    if (rc != 4) begin
      errors++;
      $display("FAIL single_ready_cycles got=%0d exp=4", rc);
    end
    checks++;
    if (obs_data.size() != 4) begin
      errors++;
      $display("FAIL single_beats got=%0d exp=4", obs_data.size());
    end
  endtask

  task automatic test_priority();
    int exp_order[9] = '{1, 2, 0, 1, 2, 0, 1, 2, 0};
    setup();
    prio[0] = 2'd2; prio[1] = 2'd0; prio[2] = 2'd1;
    for (int i = 0; i < 3; i++) src_left[i] = 4;
    apply_reset();
    for (int c = 0; c < 50; c++) begin
      if (src_left[0] == 0 && src_left[1] == 0 && src_left[2] == 0)
        for (int i = 0; i < 3; i++) src_left[i] = 4;
      present();
      checks++;
      if (act_out() !== exp_out()) begin
        errors++;
        $display("FAIL priority c=%0d got=%h exp=%h", c, act_out(), exp_out());
      end
      advance();
    end
    for (int g = 0; g < 9; g++) begin
      checks++;
      if (g >= obs_grant.size() || obs_grant[g] != exp_order[g]) begin
        errors++;
        $display("FAIL priority_order g=%0d got=%0d exp=%0d", g,
                 (g < obs_grant.size()) ? obs_grant[g] : -1, exp_order[g]);
      end
    end
  endtask

  task automatic test_round_robin();
    int          exp_order[4] = '{0, 1, 2, 0};
    logic [31:0] w;
    setup();
    for (int i = 0; i < 3; i++) begin
      prio[i]     = 2'd1;
      len[i]      = 3'd1;
      src_left[i] = 1000;
    end
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      present();
      checks++;
      if (act_out() !== exp_out()) begin
        errors++;
        $display("FAIL rr c=%0d got=%h exp=%h", c, act_out(), exp_out());
      end
      advance();
    end
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (g >= obs_grant.size() || obs_grant[g] != exp_order[g]) begin
        errors++;
        $display("FAIL rr_order g=%0d got=%0d exp=%0d", g,
                 (g < obs_grant.size()) ? obs_grant[g] : -1, exp_order[g]);
      end
    end
    for (int k = 0; k < 24; k++) begin
      w = {8'(k / 8), 24'(k % 8)};
      checks++;
      if (k >= obs_data.size() || obs_data[k] !== w) begin
        errors++;
        $display("FAIL rr_data k=%0d got=%h exp=%h", k,
                 (k < obs_data.size()) ? obs_data[k] : 32'hx, w);
      end
    end
  endtask

  task automatic test_backpressure();
    bit          seen = 0;
    bit          done = 0;
    logic [31:0] w;
    setup();
    src_left[2] = 100;
    len[2]      = 3'd2;
    rdy_mode    = 1;
    apply_reset();
    for (int c = 0; c < 80 && !done; c++) begin
      present();
      checks++;
      if (act_out() !== exp_out()) begin
        errors++;
        $display("FAIL bp c=%0d got=%h exp=%h", c, act_out(), exp_out());
      end
      if (seen && bus.arb_uplink_chid == 2'b00) done = 1;
      else begin
        if (bus.arb_uplink_chid != 2'b00) seen = 1;
        advance();
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL bp_timeout got=busy exp=idle within 80 cycles");
    end
    checks++;
    if (obs_data.size() != 16) begin
      errors++;
      $display("FAIL bp_handshakes got=%0d exp=16", obs_data.size());
    end
    for (int k = 0; k < 16 && k < obs_data.size(); k++) begin
      w = {8'd2, 24'(k)};
      checks++;
      if (obs_data[k] !== w) begin
        errors++;
        $display("FAIL bp_order k=%0d got=%h exp=%h", k, obs_data[k], w);
      end
    end
  endtask

  task automatic test_mid_change();
    bit changed = 0;
    int n0 = 0;
    int g0 = 0;
    setup();
    en          = 3'b011;
    prio[1]     = 2'd1;
    src_left[0] = 100;
    src_left[1] = 100;
    apply_reset();
    for (int c = 0; c < 30; c++) begin
      if (!changed && obs_data.size() == 2) begin
        en[0]   = 1'b0;
        len[0]  = 3'd7;
        prio[0] = 2'd3;
        changed = 1;
      end
      present();
      checks++;
      if (act_out() !== exp_out()) begin
        errors++;
        $display("FAIL mid c=%0d got=%h exp=%h", c, act_out(), exp_out());
      end
      advance();
    end
    foreach (obs_data[k]) if (obs_data[k][31:24] == 8'd0) n0++;
    foreach (obs_grant[k]) if (obs_grant[k] == 0) g0++;
    checks++;
    if (n0 != 4) begin
      errors++;
      $display("FAIL mid_ch0_beats got=%0d exp=4", n0);
    end
    checks++;
    if (g0 != 1 || obs_grant.size() < 2 || obs_grant[0] != 0 || obs_grant[1] != 1) begin
      errors++;
      $display("FAIL mid_grants got_ch0_grants=%0d total=%0d exp_ch0_grants=1 then ch1", g0, obs_grant.size());
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    setup();
    for (int i = 0; i < 3; i++) begin
      prio[i]     = 2'd1;
      len[i]      = 3'd1;
      src_left[i] = 1000;
    end
    apply_reset();
    // Pulse reset on beat 5 of ch1's packet so a non-reset arbiter would pick ch2 next.
    for (int c = 0; c < 40 && !hit; c++) begin
      present();
      checks++;
      if (act_out() !== exp_out()) begin
        errors++;
        $display("FAIL rst_mid c=%0d got=%h exp=%h", c, act_out(), exp_out());
      end
      if (obs_data.size() == 13) hit = 1;
      else advance();
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rst_mid_reach got=%0d beats exp=13", obs_data.size());
    end
    rst    = 1'b1;
    m_busy = 0;
    m_last = 2;
    #1;
    checks++;
    if (act_out() !== 38'd0) begin
      errors++;
      $display("FAIL rst_mid_async got=%h exp=0", act_out());
    end
    advance();
    advance();
    rst = 1'b0;
    obs_grant.delete();
    obs_data.delete();
    for (int c = 0; c < 6; c++) begin
      present();
      checks++;
      if (act_out() !== exp_out()) begin
        errors++;
        $display("FAIL rst_mid_after c=%0d got=%h exp=%h", c, act_out(), exp_out());
      end
      advance();
    end
    checks++;
    if (obs_grant.size() < 1 || obs_grant[0] != 0) begin
      errors++;
      $display("FAIL rst_mid_regrant got=%0d exp=0", (obs_grant.size() > 0) ? obs_grant[0] : -1);
    end
  endtask

  task automatic test_random();
    setup();
    rdy_mode = 2;
    drop_en  = 1;
    for (int i = 0; i < 3; i++) src_left[i] = $urandom_range(40, 1);
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (src_left[i] == 0 && $urandom_range(3) == 0) src_left[i] = $urandom_range(40, 1);
        if ($urandom_range(15) == 0) prio[i] = 2'($urandom_range(3));
        if ($urandom_range(15) == 0) len[i] = 3'($urandom_range(7));
      end
      if ($urandom_range(15) == 0) en = 3'($urandom_range(7));
      present();
      checks++;
      if (act_out() !== exp_out()) begin
        errors++;
        $display("FAIL random c=%0d got=%h exp=%h", c, act_out(), exp_out());
      end
      advance();
    end
    checks++;
    if (obs_data.size() < 50) begin
      errors++;
      $display("FAIL random_traffic got=%0d handshakes exp>=50", obs_data.size());
    end
  endtask

  initial begin
    setup();
    @(negedge clk);
    test_reset();
    test_single();
    test_priority();
    test_round_robin();
    test_backpressure();
    test_mid_change();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
